// File: rtl/dbi_pkg.sv
// Shared definitions for the 16-bit AC data-bus-inversion encoder and decoder.
package dbi_pkg;
  localparam int DBI_BW    = 16;
  localparam int DBI_CNT_W = $clog2(DBI_BW + 2);
  localparam int DBI_FLAG  = DBI_BW;

  typedef logic [DBI_BW:0]      dbi_word_t;
  typedef logic [DBI_CNT_W-1:0] dbi_cnt_t;
endpackage

// File: rtl/popcount_16b.sv
// Combinational population count of a DBI_BW-bit vector.
module popcount_16b
  import dbi_pkg::*;
(
  input  logic [DBI_BW-1:0] vec_i,
  output dbi_cnt_t          cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < DBI_BW; i++) begin
      cnt_o = cnt_o + dbi_cnt_t'(vec_i[i]);
    end
  end

endmodule

// File: rtl/dbi_encode_16b.sv
// Two-stage AC-DBI transmit encoder; data_out is the bus state itself.
// Optional statistics outputs are enabled by defining DBI_STATS_EN.
module dbi_encode_16b
  import dbi_pkg::*;
#(
  parameter int bw = DBI_BW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dbi_en,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [bw-1:0] data_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [bw:0]   data_out
`ifdef DBI_STATS_EN
  ,
  output logic [31:0]   toggle_cnt,
  output logic [15:0]   inv_cnt
`endif
);

  // Handshake: a word moves across an interface on a cycle where valid and
  // ready are both high at the rising edge; valid never depends on ready.
  logic          a_valid_q, a_valid_d;
  logic [bw-1:0] a_data_q, a_data_d;
  logic          out_valid_q, out_valid_d;
  logic [bw:0]   data_out_q, data_out_d;

  logic     a_load, b_load;
  dbi_cnt_t pc, cost_keep, cost_inv;
  logic     invert;
  logic [bw:0] enc;

  assign b_load   = a_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !a_valid_q || b_load;
  assign a_load   = in_valid && in_ready;

  popcount_16b u_pc_decide (
    .vec_i (a_data_q ^ data_out_q[bw-1:0]),
    .cnt_o (pc)
  );

  // Costs count line toggles against the word currently driven, flag included.
  always_comb begin
    cost_keep = pc + dbi_cnt_t'(data_out_q[bw] != 1'b0);
    cost_inv  = dbi_cnt_t'(bw) - pc + dbi_cnt_t'(data_out_q[bw] != 1'b1);
    invert    = dbi_en && (cost_inv < cost_keep);
    enc       = invert ? {1'b1, ~a_data_q} : {1'b0, a_data_q};
  end

  always_comb begin
    a_valid_d   = a_valid_q;
    a_data_d    = a_data_q;
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    if (a_load) begin
      a_valid_d = 1'b1;
      a_data_d  = data_in;
    end else if (b_load) begin
      a_valid_d = 1'b0;
    end
    // The bus only moves on a new word; idling must not disturb the reference.
    if (b_load) begin
      out_valid_d = 1'b1;
      data_out_d  = enc;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid_q   <= 1'b0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      a_valid_q   <= a_valid_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
    end
  end

  always_ff @(posedge clk) begin
    a_data_q <= a_data_d;
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;

`ifdef DBI_STATS_EN
  dbi_cnt_t    pc_tog, tog;
  logic [32:0] tog_sum;
  logic [31:0] toggle_cnt_q, toggle_cnt_d;
  logic [15:0] inv_cnt_q, inv_cnt_d;

  popcount_16b u_pc_stats (
    .vec_i (enc[bw-1:0] ^ data_out_q[bw-1:0]),
    .cnt_o (pc_tog)
  );

  always_comb begin
    tog          = pc_tog + dbi_cnt_t'(enc[bw] != data_out_q[bw]);
    tog_sum      = {1'b0, toggle_cnt_q} + 33'(tog);
    toggle_cnt_d = toggle_cnt_q;
    inv_cnt_d    = inv_cnt_q;
    if (b_load) begin
      toggle_cnt_d = tog_sum[32] ? '1 : tog_sum[31:0];
      if (enc[bw] && (inv_cnt_q != '1)) begin
        inv_cnt_d = inv_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      toggle_cnt_q <= '0;
      inv_cnt_q    <= '0;
    end else begin
      toggle_cnt_q <= toggle_cnt_d;
      inv_cnt_q    <= inv_cnt_d;
    end
  end

  assign toggle_cnt = toggle_cnt_q;
  assign inv_cnt    = inv_cnt_q;
`endif

endmodule

// File: tb/tb_dbi_encode_16b.sv
// Self-checking bench for dbi_encode_16b: directed scenarios plus random traffic.
module tb_dbi_encode_16b;

  logic        clk = 1'b0;
  logic        reset;
  logic        dbi_en;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] data_out;
`ifdef DBI_STATS_EN
  logic [31:0] toggle_cnt;
  logic [15:0] inv_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [16:0] exp_q[$];
  logic [16:0] model_prev;

  dbi_encode_16b dut (
    .clk       (clk),
    .reset     (reset),
    .dbi_en    (dbi_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
`ifdef DBI_STATS_EN
    ,
    .toggle_cnt(toggle_cnt),
    .inv_cnt   (inv_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; data_in = '0;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    model_prev = '0;
  endtask

  // ---------------- reference model ----------------
  // Pick whichever of the two candidate bus words flips fewer lines; ties keep.
  task automatic model_push(input logic [15:0] w, input logic en);
    logic [16:0] keep_w, inv_w, pick;
    int t_keep, t_inv;
    keep_w = {1'b0, w};
    inv_w  = {1'b1, ~w};
    t_keep = $countones(keep_w ^ model_prev);
    t_inv  = $countones(inv_w ^ model_prev);
    pick   = (en && (t_inv < t_keep)) ? inv_w : keep_w;
    model_prev = pick;
    exp_q.push_back(pick);
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic v, input logic [15:0] d, input logic ordy,
                       output logic acc, output logic fire, output logic [16:0] dout);
    @(negedge clk);
    in_valid = v; data_in = d; out_ready = ordy;
    #1;
    acc  = v && in_ready;
    fire = out_valid && ordy;
    dout = data_out;
    if (acc) model_push(d, dbi_en);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic acc, fire;
    logic [16:0] dout, e;
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; data_in = 16'hABCD; out_ready = 1'b1; dbi_en = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (data_out !== 17'h0) begin n_fail++; $display("FAIL reset_data got %h want %h", data_out, 17'h0); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    reset = 1'b0;
    exp_q.delete();
    model_prev = '0;
    model_push(16'hABCD, 1'b1);
    cycle(1'b0, 16'h0, 1'b1, acc, fire, dout);
    n_checks++;
    if (fire !== 1'b0) begin n_fail++; $display("FAIL reset_early_valid got %b want 0", fire); end
    cycle(1'b0, 16'h0, 1'b1, acc, fire, dout);
    n_checks++;
    if (fire !== 1'b1) begin n_fail++; $display("FAIL reset_first_valid got %b want 1", fire); end
    e = exp_q.pop_front();
    n_checks++;
    if (dout !== 17'h15432 || dout !== e) begin
      n_fail++; $display("FAIL reset_first_word got %h want %h", dout, 17'h15432);
    end
  endtask

  task automatic test_encoding_seq();
    logic [15:0] words[3];
    logic [16:0] consts[3];
    logic acc, fire;
    logic [16:0] dout, e;
    int got;
    words  = '{16'h00FF, 16'hFF00, 16'hFFFF};
    consts = '{17'h000FF, 17'h100FF, 17'h10000};
    do_reset();
    dbi_en = 1'b1;
    got = 0;
    for (int c = 0; c < 6; c++) begin
      cycle(c < 3, (c < 3) ? words[c] : 16'h0, 1'b1, acc, fire, dout);
      n_checks++;
      if (fire !== (c >= 2 && c <= 4)) begin
        n_fail++; $display("FAIL seq_timing cycle %0d got %b want %b", c, fire, (c >= 2 && c <= 4));
      end
      if (fire && got < 3) begin
        e = exp_q.pop_front();
        n_checks++;
        if (dout !== consts[got] || dout !== e) begin
          n_fail++; $display("FAIL seq_word %0d got %h want %h", got, dout, consts[got]);
        end
        got++;
      end
    end
  endtask

  task automatic test_passthrough();
    logic acc, fire;
    logic [16:0] dout, e;
    int got;
    do_reset();
    dbi_en = 1'b0;
    got = 0;
    cycle(1'b1, 16'hFFFF, 1'b1, acc, fire, dout);
    for (int k = 0; k < 6 && got == 0; k++) begin
      cycle(1'b0, 16'h0, 1'b1, acc, fire, dout);
      if (fire) begin
        e = exp_q.pop_front();
        n_checks++;
        if (dout !== 17'h0FFFF || dout !== e) begin
          n_fail++; $display("FAIL passthrough got %h want %h", dout, 17'h0FFFF);
        end
        got++;
      end
    end
    n_checks++;
    if (got != 1) begin n_fail++; $display("FAIL passthrough_timeout got %0d want 1", got); end
  endtask

  task automatic test_backpressure();
    logic [15:0] words[4];
    logic acc, fire;
    logic [16:0] dout, e, snap;
    int idx, got;
    for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
    do_reset();
    dbi_en = 1'b1;
    idx = 0;
    snap = '0;
    for (int c = 0; c < 6; c++) begin
      cycle(1'b1, words[idx], 1'b0, acc, fire, dout);
      if (acc) idx++;
      if (c == 2) snap = dout;
    end
    n_checks++;
    if (idx != 2) begin n_fail++; $display("FAIL bp_accepted got %0d want 2", idx); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
    n_checks++;
    if (data_out !== snap || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_stable got %h want %h", data_out, snap);
    end
    got = 0;
    for (int k = 0; k < 20 && got < 4; k++) begin
      cycle(idx < 4, words[idx < 4 ? idx : 0], 1'b1, acc, fire, dout);
      if (acc) idx++;
      if (fire) begin
        e = exp_q.pop_front();
        n_checks++;
        if (dout !== e) begin n_fail++; $display("FAIL bp_word %0d got %h want %h", got, dout, e); end
        got++;
      end
    end
    n_checks++;
    if (got != 4) begin n_fail++; $display("FAIL bp_drain got %0d want 4", got); end
  endtask

  task automatic test_idle_hold();
    logic acc, fire;
    logic [16:0] dout, e, snap;
    int got;
    do_reset();
    dbi_en = 1'b1;
    got = 0;
    cycle(1'b1, 16'($urandom), 1'b1, acc, fire, dout);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 16'h0, 1'b1, acc, fire, dout);
      if (fire) begin
        e = exp_q.pop_front();
        n_checks++;
        if (dout !== e) begin n_fail++; $display("FAIL idle_first got %h want %h", dout, e); end
        got++;
      end
    end
    snap = model_prev;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 16'h0, 1'b1, acc, fire, dout);
      n_checks++;
      if (dout !== snap) begin n_fail++; $display("FAIL idle_hold cycle %0d got %h want %h", k, dout, snap); end
    end
    cycle(1'b1, 16'($urandom), 1'b1, acc, fire, dout);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 16'h0, 1'b1, acc, fire, dout);
      if (fire) begin
        e = exp_q.pop_front();
        n_checks++;
        if (dout !== e) begin n_fail++; $display("FAIL idle_next got %h want %h", dout, e); end
        got++;
      end
    end
    n_checks++;
    if (got != 2) begin n_fail++; $display("FAIL idle_count got %0d want 2", got); end
  endtask

  task automatic test_reset_mid();
    logic acc, fire;
    logic [16:0] dout, e;
    int got;
    do_reset();
    dbi_en = 1'b1;
    for (int c = 0; c < 4; c++) cycle(1'b1, 16'($urandom), 1'b0, acc, fire, dout);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || data_out !== 17'h0) begin
      n_fail++; $display("FAIL midreset got valid %b data %h want 0 0", out_valid, data_out);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready got %b want 1", in_ready); end
    reset = 1'b0;
    exp_q.delete();
    model_prev = '0;
    got = 0;
    cycle(1'b1, 16'hFFFF, 1'b1, acc, fire, dout);
    for (int k = 0; k < 5 && got == 0; k++) begin
      cycle(1'b0, 16'h0, 1'b1, acc, fire, dout);
      if (fire) begin
        e = exp_q.pop_front();
        n_checks++;
        if (dout !== 17'h10000 || dout !== e) begin
          n_fail++; $display("FAIL midreset_word got %h want %h", dout, 17'h10000);
        end
        got++;
      end
    end
    n_checks++;
    if (got != 1) begin n_fail++; $display("FAIL midreset_timeout got %0d want 1", got); end
  endtask

  task automatic test_random();
    logic acc, fire;
    logic [16:0] dout, e;
    for (int p = 0; p < 2; p++) begin
      do_reset();
      dbi_en = (p == 0);
      for (int c = 0; c < 150; c++) begin
        cycle($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) != 0, acc, fire, dout);
        if (fire) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL rand_extra got %h want none", dout);
          end else begin
            e = exp_q.pop_front();
            if (dout !== e) begin n_fail++; $display("FAIL rand_word got %h want %h", dout, e); end
          end
        end
      end
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
        cycle(1'b0, 16'h0, 1'b1, acc, fire, dout);
        if (fire) begin
          e = exp_q.pop_front();
          n_checks++;
          if (dout !== e) begin n_fail++; $display("FAIL rand_drain got %h want %h", dout, e); end
        end
      end
      n_checks++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_lost got %0d want 0", exp_q.size()); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; dbi_en = 1'b1; in_valid = 1'b0; out_ready = 1'b1; data_in = '0;
    model_prev = '0;
    test_reset();
    test_encoding_seq();
    test_passthrough();
    test_backpressure();
    test_idle_hold();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
